// File: rtl/pc_predict_unit.sv
// Fetch PC register with a direct-mapped BTB (2-bit counters) for next-PC prediction.
// Resolves execute-stage control flow and redirects fetch on a mispredict.
module pc_predict_unit #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h00000000,
  parameter int               BTB_ENTRIES  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_jump,
  input  logic            ex_jalr,
  input  logic            ex_branch,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            redirect,
  output logic            misalign_err
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [XLEN-1:0]        r_pc;
  logic [BTB_ENTRIES-1:0] r_btbValid;
  logic [TAGW-1:0]        r_btbTag    [BTB_ENTRIES];
  logic [XLEN-1:0]        r_btbTarget [BTB_ENTRIES];
  logic [1:0]             r_btbCtr    [BTB_ENTRIES];

  logic [XLEN-1:0] w_pcPlus4;
  logic [IDX-1:0]  w_lookIdx;
  logic [TAGW-1:0] w_lookTag;
  logic            w_lookHit;
  logic            w_actTaken;
  logic [XLEN-1:0] w_actTarget;
  logic [XLEN-1:0] w_correctPc;
  logic            w_mispredict;
  logic [XLEN-1:0] w_nextPc;
  logic            w_update;
  logic [IDX-1:0]  w_exIdx;
  logic [TAGW-1:0] w_exTag;
  logic            w_exHit;

  assign w_pcPlus4 = r_pc + XLEN'(4);
  assign w_lookIdx = r_pc[IDX+1:2];
  assign w_lookTag = r_pc[XLEN-1:IDX+2];
  assign w_lookHit = r_btbValid[w_lookIdx] && (r_btbTag[w_lookIdx] == w_lookTag);

  assign pc          = r_pc;
  assign pred_taken  = w_lookHit && r_btbCtr[w_lookIdx][1];
  assign pred_target = w_lookHit ? r_btbTarget[w_lookIdx] : w_pcPlus4;

  // jalr clears bit 0 of its target; bit 1 is left for misalign_err to flag.
  assign w_actTaken  = ex_jump || (ex_branch && ex_taken);
  assign w_actTarget = (ex_jump && ex_jalr) ? ((ex_rs1 + ex_imm) & ~XLEN'(1))
                                            : (ex_pc + ex_imm);
  assign w_correctPc = w_actTaken ? w_actTarget : (ex_pc + XLEN'(4));

  assign w_mispredict = ex_valid && ((ex_pred_taken != w_actTaken) ||
                                     (w_actTaken && (ex_pred_target != w_actTarget)));
  assign redirect     = w_mispredict && !trap_valid;
  assign misalign_err = redirect && w_correctPc[1];

  always_comb begin
    w_nextPc = w_pcPlus4;
    if (trap_valid)      w_nextPc = trap_target;
    else if (redirect)   w_nextPc = w_correctPc;
    else if (stall)      w_nextPc = r_pc;
    else if (pred_taken) w_nextPc = pred_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_VECTOR;
    else        r_pc <= w_nextPc;
  end

  assign w_update = ex_valid && (ex_jump || ex_branch) && !trap_valid;
  assign w_exIdx  = ex_pc[IDX+1:2];
  assign w_exTag  = ex_pc[XLEN-1:IDX+2];
  assign w_exHit  = r_btbValid[w_exIdx] && (r_btbTag[w_exIdx] == w_exTag);

  // Only the valid bits need reset; payload of an invalid entry is never observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btbValid <= '0;
    end else if (w_update && !w_exHit && w_actTaken) begin
      r_btbValid[w_exIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_update) begin
      if (w_exHit) begin
        if (w_actTaken) begin
          if (r_btbCtr[w_exIdx] != 2'd3) r_btbCtr[w_exIdx] <= r_btbCtr[w_exIdx] + 2'd1;
          r_btbTarget[w_exIdx] <= w_actTarget;
        end else if (r_btbCtr[w_exIdx] != 2'd0) begin
          r_btbCtr[w_exIdx] <= r_btbCtr[w_exIdx] - 2'd1;
        end
      end else if (w_actTaken) begin
        r_btbTag[w_exIdx]    <= w_exTag;
        r_btbTarget[w_exIdx] <= w_actTarget;
        r_btbCtr[w_exIdx]    <= ex_jump ? 2'd3 : 2'd2;
      end
    end
  end

endmodule
